// File: rtl/bf_io_pkg.sv
// Shared types for the bf I/O bridge: byte width and the read/write handshake FSM states.
package bf_io_pkg;

  localparam int BF_DATA_W = 8;

  typedef enum logic [1:0] {R_IDLE, R_ADV, R_DROP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE} wr_state_t;

endpackage

// File: rtl/bf_io_sync.sv
// Multi-flop synchroniser for a single asynchronous device handshake line; clears to 0 on reset.
module bf_io_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/bf_io_ctrl.sv
// bf core <-> I/O bus bridge: ',' reads via setready/dataready, '.' writes via a FIFO and ready/received.
// Optional IO_TIMEOUT_EN adds per-FSM stall counters that abandon a hung device handshake.
module bf_io_ctrl
  import bf_io_pkg::*;
#(
  parameter int DATA_W      = BF_DATA_W,
  parameter int OFIFO_DEPTH = 4,
  parameter int SYNC_STAGES = 2
`ifdef IO_TIMEOUT_EN
  ,
  parameter int TIMEOUT     = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              dev_setready,
  input  logic              dev_dataready,
  input  logic [DATA_W-1:0] dev_in,
  output logic              dev_out_ready,
  output logic [DATA_W-1:0] dev_out,
  input  logic              dev_received,
  output logic              busy,
  output logic              err_timeout
);

  localparam int AW = $clog2(OFIFO_DEPTH);
  localparam int CW = AW + 1;

  // Core write port: a byte transfers on any cycle where wr_valid && wr_ready;
  // wr_valid/wr_data must hold while wr_ready is low.

  logic drdy_s, rcv_s, rcv_s_d1, rcv_rise;

  bf_io_sync #(.STAGES(SYNC_STAGES)) u_sync_drdy (
    .clk(clk), .rst_n(rst_n), .d(dev_dataready), .q(drdy_s)
  );

  bf_io_sync #(.STAGES(SYNC_STAGES)) u_sync_rcv (
    .clk(clk), .rst_n(rst_n), .d(dev_received), .q(rcv_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcv_s_d1 <= 1'b0;
    else        rcv_s_d1 <= rcv_s;
  end

  assign rcv_rise = rcv_s & ~rcv_s_d1;

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;
  logic      rd_take, rd_tmo, wr_tmo;

  // Output FIFO
  logic [DATA_W-1:0] mem [OFIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic              push, pop;

  assign wr_ready = (count != CW'(OFIFO_DEPTH));
  assign push     = wr_valid & wr_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read FSM
  always_comb begin
    rd_next = rd_state;
    rd_take = 1'b0;
    unique case (rd_state)
      R_IDLE: if (rd_req && drdy_s) begin
        rd_next = R_ADV;
        rd_take = 1'b1;
      end
      R_ADV:   if (!drdy_s) rd_next = R_DROP;
      R_DROP:  if (drdy_s)  rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
    if (rd_tmo) begin
      rd_next = R_IDLE;
      rd_take = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state     <= R_IDLE;
      rd_ack       <= 1'b0;
      rd_data      <= '0;
      dev_setready <= 1'b0;
    end else begin
      rd_state     <= rd_next;
      rd_ack       <= rd_take | rd_tmo;
      dev_setready <= (rd_next == R_ADV);
      if (rd_take)     rd_data <= dev_in;
      else if (rd_tmo) rd_data <= '0;
    end
  end

  // Write FSM: one setup cycle keeps dev_out_ready low between consecutive bytes.
  always_comb begin
    wr_next = wr_state;
    pop     = 1'b0;
    unique case (wr_state)
      W_IDLE: if (count != '0) begin
        wr_next = W_SETUP;
        pop     = 1'b1;
      end
      W_SETUP:  wr_next = W_STROBE;
      W_STROBE: if (rcv_rise) wr_next = W_IDLE;
      default:  wr_next = W_IDLE;
    endcase
    if (wr_tmo) wr_next = W_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state      <= W_IDLE;
      dev_out_ready <= 1'b0;
      dev_out       <= '0;
    end else begin
      wr_state      <= wr_next;
      dev_out_ready <= (wr_next == W_STROBE);
      if (pop) dev_out <= mem[rptr];
    end
  end

  assign busy = (count != '0) | (rd_state != R_IDLE) | (wr_state != W_IDLE);

`ifdef IO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] rd_cnt, wr_cnt;
  logic          rd_run, wr_run;

  assign rd_run = (rd_state != R_IDLE) | (rd_req & ~drdy_s);
  assign wr_run = (wr_state == W_STROBE);
  assign rd_tmo = rd_run & (rd_cnt == TW'(TIMEOUT - 1));
  assign wr_tmo = wr_run & (wr_cnt == TW'(TIMEOUT - 1));

  // Counters restart on any state change so each handshake phase gets a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!rd_run || rd_tmo || (rd_next != rd_state)) rd_cnt <= '0;
      else                                            rd_cnt <= rd_cnt + 1'b1;
      if (!wr_run || wr_tmo || (wr_next != wr_state)) wr_cnt <= '0;
      else                                            wr_cnt <= wr_cnt + 1'b1;
      if (rd_tmo || wr_tmo) err_timeout <= 1'b1;
    end
  end
`else
  assign rd_tmo      = 1'b0;
  assign wr_tmo      = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bf_io_ctrl.sv
// Self-checking bench for bf_io_ctrl: behavioural input/output bus devices plus read/write scoreboards.
module tb_bf_io_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       dev_setready;
  logic       dev_dataready = 1'b0;
  logic [7:0] dev_in = 8'h00;
  logic       dev_out_ready;
  logic [7:0] dev_out;
  logic       dev_received = 1'b0;
  logic       busy;
  logic       err_timeout;

  bf_io_ctrl #(
    .DATA_W(8), .OFIFO_DEPTH(4), .SYNC_STAGES(2)
`ifdef IO_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .dev_setready(dev_setready), .dev_dataready(dev_dataready), .dev_in(dev_in),
    .dev_out_ready(dev_out_ready), .dev_out(dev_out), .dev_received(dev_received),
    .busy(busy), .err_timeout(err_timeout)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues
  logic [7:0] in_q[$];
  logic [7:0] rd_exp_q[$];
  logic [7:0] out_exp_q[$];

  // Input bus device: presents the queue head, consumes it on setready.
  int in_st = 0, in_cnt = 0;
  bit in_en = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_st = 0; in_cnt = 0; dev_dataready = 1'b0;
    end else begin
      case (in_st)
        0: if (in_en && in_q.size() > 0) begin dev_in = in_q[0]; in_cnt = 3; in_st = 1; end
        1: if (in_cnt > 0) in_cnt--; else begin dev_dataready = 1'b1; in_st = 2; end
        2: if (dev_setready) begin void'(in_q.pop_front()); in_cnt = 4; in_st = 3; end
        3: if (in_cnt > 0) in_cnt--; else begin dev_dataready = 1'b0; in_st = 4; end
        4: if (!dev_setready) begin in_cnt = 3; in_st = 5; end
        5: if (in_cnt > 0) in_cnt--; else in_st = 0;
        default: in_st = 0;
      endcase
    end
  end

  // Output bus device: takes dev_out when strobed, answers with a received pulse.
  int o_st = 0, o_cnt = 0;
  bit out_stall = 1'b0;
  logic [7:0] out_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      o_st = 0; o_cnt = 0; dev_received = 1'b0;
    end else begin
      case (o_st)
        0: if (dev_out_ready && !out_stall) begin
          if (out_exp_q.size() == 0) check("dev_out_expected_q", 32'(out_exp_q.size()), 1);
          else begin
            out_e = out_exp_q.pop_front();
            check("dev_out", 32'(dev_out), 32'(out_e));
          end
          o_cnt = 4; o_st = 1;
        end
        1: if (o_cnt > 0) o_cnt--; else begin dev_received = 1'b1; o_st = 2; end
        2: if (!dev_out_ready) begin o_cnt = 4; o_st = 3; end
        3: if (o_cnt > 0) o_cnt--; else begin dev_received = 1'b0; o_st = 0; end
        default: o_st = 0;
      endcase
    end
  end

  // Read monitor: every rd_ack consumes one expected byte.
  int   ack_count = 0, sr_rises = 0;
  logic sr_d = 1'b0;
  logic [7:0] rd_e;
  always @(negedge clk) begin
    if (rst_n && rd_ack) begin
      ack_count++;
      if (rd_exp_q.size() == 0) check("rd_exp_q", 32'(rd_exp_q.size()), 1);
      else begin
        rd_e = rd_exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(rd_e));
      end
    end
    if (dev_setready && !sr_d) sr_rises++;
    sr_d = dev_setready;
  end

  // Driver tasks
  task automatic do_read(input logic [7:0] exp);
    int n = 0;
    rd_exp_q.push_back(exp);
    rd_req = 1'b1;
    @(negedge clk);
    while (!rd_ack && n < 100) begin n++; @(negedge clk); end
    check("rd_ack_seen", 32'(rd_ack), 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit track);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    while (!wr_ready && n < 200) begin n++; @(negedge clk); end
    check("wr_ready_seen", 32'(wr_ready), 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (track) out_exp_q.push_back(b);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((out_exp_q.size() != 0 || busy) && n < 400) begin n++; @(negedge clk); end
    check(tag, 32'(out_exp_q.size()) + 32'(busy), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int n;
  int ack0, sr0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rd_ack", 32'(rd_ack), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_setready", 32'(dev_setready), 0);
    check("rst_out_ready", 32'(dev_out_ready), 0);
    check("rst_dev_out", 32'(dev_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);

    // 1: three reads in order; 8'h44 stays queued so the read FSM can return to idle
    @(posedge clk); #1;
    ack0 = ack_count; sr0 = sr_rises;
    in_q.push_back(8'h41); in_q.push_back(8'h42); in_q.push_back(8'h43); in_q.push_back(8'h44);
    do_read(8'h41);
    do_read(8'h42);
    do_read(8'h43);
    check("t1_acks", 32'(ack_count - ack0), 3);
    check("t1_setready_rises", 32'(sr_rises - sr0), 3);

    // 2: five back-to-back writes with the output device stalled
    out_stall = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'h61 + i), 1'b1);
    @(negedge clk);
    // four FIFO entries plus the byte already held on dev_out
    check("t2_wr_ready_full", 32'(wr_ready), 0);
    check("t2_busy_stalled", 32'(busy), 1);
    out_stall = 1'b0;
    n = 0;
    while (out_exp_q.size() != 0 && n < 300) begin n++; @(negedge clk); end
    check("t2_all_out", 32'(out_exp_q.size()), 0);
    check("t2_busy_before_rcv", 32'(busy), 1);
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    check("t2_busy_fall", 32'(busy), 0);
    check("t2_rcv_high_at_idle", 32'(dev_received), 1);

    // 3: concurrent read and write
    in_q.push_back(8'h45);
    @(posedge clk); #1;
    fork
      do_read(8'h44);
      push_byte(8'h2E, 1'b1);
    join
    wait_drain("t3_drain");
    check("t3_err", 32'(err_timeout), 0);

    // 4a: reset during W_STROBE
    out_stall = 1'b1;
    push_byte(8'hA5, 1'b0);
    n = 0;
    while (!dev_out_ready && n < 50) begin n++; @(negedge clk); end
    check("t4_in_strobe", 32'(dev_out_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t4w_out_ready", 32'(dev_out_ready), 0);
    check("t4w_dev_out", 32'(dev_out), 0);
    check("t4w_busy", 32'(busy), 0);
    check("t4w_rd_data", 32'(rd_data), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_stall = 1'b0;

    // 4b: reset during R_ADV
    in_q.push_back(8'h46);
    repeat (20) @(negedge clk);
    rd_exp_q.push_back(8'h45);
    rd_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rd_ack && n < 100) begin n++; @(negedge clk); end
    check("t4r_ack_seen", 32'(rd_ack), 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    check("t4r_in_adv", 32'(dev_setready), 1);
    rst_n = 1'b0;
    #1;
    check("t4r_setready", 32'(dev_setready), 0);
    check("t4r_rd_data", 32'(rd_data), 0);
    check("t4r_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    in_q.push_back(8'h47);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    do_read(8'h46);
    push_byte(8'h5C, 1'b1);
    wait_drain("t4_drain");

    // 5: device never offers data while a read is pending
    in_en = 1'b0;
    pulse_reset();
    repeat (5) @(posedge clk);
    #1;
    ack0 = ack_count;
`ifdef IO_TIMEOUT_EN
    rd_exp_q.push_back(8'h00);
    rd_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rd_ack && n < 60) begin n++; @(negedge clk); end
    check("t5_eof_ack", 32'(rd_ack), 1);
    check("t5_latency", 32'(n), 16);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check("t5_err_set", 32'(err_timeout), 1);
    repeat (20) @(negedge clk);
    check("t5_err_sticky", 32'(err_timeout), 1);
    check("t5_one_ack", 32'(ack_count - ack0), 1);
`else
    rd_exp_q.push_back(8'h47);
    rd_req = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_still_pending", 32'(ack_count - ack0), 0);
    check("t5_err_zero", 32'(err_timeout), 0);
    in_en = 1'b1;
    n = 0;
    while (!rd_ack && n < 100) begin n++; @(negedge clk); end
    check("t5_late_ack", 32'(rd_ack), 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check("t5_one_ack", 32'(ack_count - ack0), 1);
    check("t5_err_still_zero", 32'(err_timeout), 0);
`endif

    repeat (10) @(negedge clk);
    check("end_rd_q_empty", 32'(rd_exp_q.size()), 0);
    check("end_out_q_empty", 32'(out_exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
